// File: rtl/k12a_mem_sequencer_pkg.sv
// Shared types and constants for the k12a memory sequencer.
//   mem_seq_state_t : bus-cycle phase (IDLE, SETUP, STROBE, HOLD)
//   MEM_RAM_SEL_BIT : address bit that selects RAM (1) or ROM (0)
//   WAIT_CNT_W      : width of the strobe wait-state down-counter
package k12a_mem_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } mem_seq_state_t;

    localparam int MEM_RAM_SEL_BIT = 15;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/k12a_mem_sequencer_if.sv
// CPU-side request/response bundle of the k12a memory sequencer.
//   req_valid/req_ready : request handshake; req_write/req_addr/req_wdata qualify it
//   rsp_valid           : one-cycle completion pulse; rsp_rdata/rsp_error qualify it
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The master holds req_* stable while req_valid is
// high and req_ready is low. After the transfer the slave owns a private copy,
// so req_* may change freely. Responses have no back-pressure: rsp_valid is
// high for exactly one cycle and the master must take it then.
interface k12a_mem_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/k12a_mem_sequencer.sv
// Bus master in front of k12a_memory. Takes single-byte requests from the
// CPU, decodes ROM/RAM from addr[15] and runs the asynchronous-SRAM strobe
// sequence SETUP -> STROBE (WAIT_STATES+1 cycles) -> HOLD, then reports
// completion on a one-cycle response pulse.
//   clock, reset      : system clock, asynchronous active-high reset
//   cpu (slave)       : request/response handshake
//   addr_out/data_out : address and write data for the top-level buses
//   data_drive        : 1 = top level drives data_out onto data_bus
//   data_in           : data_bus as seen by the sequencer
//   mem_*_n           : chip enables, output enable, write enable (active low)
//   dbg_state         : current FSM state
module k12a_mem_sequencer
    import k12a_mem_sequencer_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    k12a_mem_sequencer_if.slave        cpu,
    output logic [15:0]                addr_out,
    output logic [7:0]                 data_out,
    output logic                       data_drive,
    input  logic [7:0]                 data_in,
    output logic                       mem_rom_ce_n,
    output logic                       mem_ram_ce_n,
    output logic                       mem_oe_n,
    output logic                       mem_we_n,
    output mem_seq_state_t             dbg_state
);

    localparam logic [WAIT_CNT_W-1:0] WS_INIT = 4'(WAIT_STATES);

    mem_seq_state_t        state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [15:0]           addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  rom_ce_n_q, rom_ce_n_d;
    logic                  ram_ce_n_q, ram_ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  drive_q, drive_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  ram_sel_d;
    logic                  suppress_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rom_ce_n_q  <= 1'b1;
            ram_ce_n_q  <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rom_ce_n_q  <= rom_ce_n_d;
            ram_ce_n_q  <= ram_ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu.req_valid) begin
                    state_d = SETUP;
                    write_d = cpu.req_write;
                    addr_d  = cpu.req_addr;
                    wdata_d = cpu.req_wdata;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = WS_INIT;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    // Sample the bus at the end of the last strobe cycle.
                    if (!write_q) begin
                        rdata_d = data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every pin is registered, so the pin values for the coming cycle are
        // derived from the next state and the (possibly just latched) request.
        ram_sel_d  = addr_d[MEM_RAM_SEL_BIT];
        // A write aimed at ROM runs the full timing but never touches the pins.
        suppress_d = write_d && !ram_sel_d;

        rom_ce_n_d  = 1'b1;
        ram_ce_n_d  = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        drive_d     = 1'b0;
        rsp_valid_d = (state_d == HOLD);
        rsp_error_d = (state_d == HOLD) && suppress_d;

        if ((state_d != IDLE) && !suppress_d) begin
            if (ram_sel_d) begin
                ram_ce_n_d = 1'b0;
            end else begin
                rom_ce_n_d = 1'b0;
            end
            drive_d = write_d;
        end

        if ((state_d == STROBE) && !suppress_d) begin
            oe_n_d = write_d;
            we_n_d = !write_d;
        end
    end

    assign cpu.req_ready = (state_q == IDLE);
    assign cpu.rsp_valid = rsp_valid_q;
    assign cpu.rsp_rdata = rdata_q;
    assign cpu.rsp_error = rsp_error_q;

    assign addr_out     = addr_q;
    assign data_out     = wdata_q;
    assign data_drive   = drive_q;
    assign mem_rom_ce_n = rom_ce_n_q;
    assign mem_ram_ce_n = ram_ce_n_q;
    assign mem_oe_n     = oe_n_q;
    assign mem_we_n     = we_n_q;
    assign dbg_state    = state_q;

endmodule
